// File: rtl/clk_div_pkg.sv
// Shared defaults and per-channel state type for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT       = 8;
    localparam int LOCK_CYCLES_DEFAULT = 16;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Width of a counter that must reach cycles-1; never narrower than one bit.
    function automatic int lock_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: 50% duty output with a pulse on the first high cycle.
// The divide value is only sampled at start-up and at each period boundary.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_ok,
    input  logic             align,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             clk_div,
    output logic             clk_en
);

    ch_state_e        state;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             start_ok;
    logic             wrap;

    // A zero divide value behaves exactly like a disabled channel.
    assign start_ok = en && (div != '0);
    assign wrap     = (cnt == active - CNT_W'(1));
    assign clk_div  = phase;

    // NOTE: every register here uses <= so all of them see the pre-edge values of
    // cnt/phase/state; a blocking assignment would let later lines see updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CH_IDLE;
            active <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            clk_en <= 1'b0;
        end else if (!run_ok) begin
            state  <= CH_IDLE;
            active <= '0;
            cnt    <= '0;
            phase  <= 1'b0;
            clk_en <= 1'b0;
        end else begin
            clk_en <= 1'b0;
            if (align && state == CH_RUN) begin
                // Phase restart wins over any wrap landing on the same edge.
                cnt   <= '0;
                phase <= 1'b0;
                if (start_ok) begin
                    active <= div;
                end else begin
                    state <= CH_IDLE;
                end
            end else begin
                case (state)
                    CH_IDLE: begin
                        if (start_ok) begin
                            state  <= CH_RUN;
                            active <= div;
                        end
                    end
                    CH_RUN: begin
                        if (wrap) begin
                            cnt   <= '0;
                            phase <= !phase;
                            if (phase) begin
                                // Period boundary: the only place a new divide value lands.
                                if (start_ok) begin
                                    active <= div;
                                end else begin
                                    state <= CH_IDLE;
                                end
                            end else begin
                                clk_en <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider with a lock counter standing in for MMCM LOCKED.
// Define CLKDIV_ALIGN_EN to let alignReq_i restart all running channels in phase.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic                    sysClk_i,
    input  logic                    RESETn_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       chEn_i,
    input  logic                    alignReq_i,
    output logic [NUM_CH-1:0]       clkDiv_o,
    output logic [NUM_CH-1:0]       clkEn_o,
    output logic                    locked_o
);

    localparam int LOCK_W = lock_cnt_width(LOCK_CYCLES);

    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_hit;
    logic              run_ok;
    logic              align;

    assign lock_hit = !locked_o && (lock_cnt == LOCK_W'(LOCK_CYCLES - 1));
    // Channels start on the same edge that raises locked_o.
    assign run_ok   = locked_o || lock_hit;

    always_ff @(posedge sysClk_i or negedge RESETn_i) begin
        if (!RESETn_i) begin
            lock_cnt <= '0;
            locked_o <= 1'b0;
        end else if (!locked_o) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
            if (lock_hit) begin
                locked_o <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_ALIGN_EN
    assign align = alignReq_i && locked_o;
`else
    logic unused_align_req;
    assign unused_align_req = alignReq_i;
    assign align            = 1'b0;
`endif

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        clk_div_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (sysClk_i),
            .rst_n   (RESETn_i),
            .run_ok  (run_ok),
            .align   (align),
            .en      (chEn_i[n]),
            .div     (div_i[n*CNT_W +: CNT_W]),
            .clk_div (clkDiv_o[n]),
            .clk_en  (clkEn_o[n])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a period-level reference model predicts every rising
// edge and high width; a negedge monitor consumes those predictions.
module tb_clk_div_multi;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int LOCK   = 16;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic [NUM_CH*CNT_W-1:0] div       = '0;
    logic [NUM_CH-1:0]       ch_en     = '0;
    logic                    align_req = 1'b0;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       clk_en;
    logic                    locked;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .sysClk_i   (clk),
        .RESETn_i   (rst_n),
        .div_i      (div),
        .chEn_i     (ch_en),
        .alignReq_i (align_req),
        .clkDiv_o   (clk_div),
        .clkEn_o    (clk_en),
        .locked_o   (locked)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
    endtask

    task automatic set_div(input int ch, input int v);
        div[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // ---------------- reference model ----------------
    // A running channel is described by its period start cycle t0 and divide a:
    // rising edge at t0+a, period end (and next divide sample) at t0+2a.
    typedef struct {
        int rise;
        int width;
        int epoch;
    } item_t;

    item_t exp_q [NUM_CH][$];
    int    cyc        = 0;
    int    lock_edges = 0;
    bit    run_m [NUM_CH];
    int    t0    [NUM_CH];
    int    a_m   [NUM_CH];
    int    epoch [NUM_CH];

    function automatic void model_flush();
        lock_edges = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            exp_q[ch].delete();
            run_m[ch] = 1'b0;
            epoch[ch]++;
        end
    endfunction

    function automatic void model_start(input int ch, input int d);
        item_t it;
        run_m[ch] = 1'b1;
        t0[ch]    = cyc;
        a_m[ch]   = d;
        it.rise   = cyc + d;
        it.width  = d;
        it.epoch  = epoch[ch];
        exp_q[ch].push_back(it);
    endfunction

    function automatic void model_channel(input int ch, input bit al);
        int d;
        bit go;
        d  = int'(div[ch*CNT_W +: CNT_W]);
        go = ch_en[ch] && (d != 0);
        if (al && run_m[ch]) begin
            epoch[ch]++;
            if (t0[ch] + a_m[ch] >= cyc && exp_q[ch].size() > 0)
                exp_q[ch].delete(exp_q[ch].size() - 1);
            if (go) model_start(ch, d);
            else    run_m[ch] = 1'b0;
        end else if (run_m[ch]) begin
            if (cyc == t0[ch] + 2 * a_m[ch]) begin
                if (go) model_start(ch, d);
                else    run_m[ch] = 1'b0;
            end
        end else if (go) begin
            model_start(ch, d);
        end
    endfunction

    always @(posedge clk) begin
        bit was_locked;
        bit al;
        cyc++;
        if (!rst_n) begin
            model_flush();
        end else begin
            was_locked = (lock_edges >= LOCK);
            lock_edges++;
`ifdef CLKDIV_ALIGN_EN
            al = was_locked && align_req;
`else
            al = 1'b0;
`endif
            if (lock_edges >= LOCK)
                for (int ch = 0; ch < NUM_CH; ch++) model_channel(ch, al);
        end
    end

    always @(negedge rst_n) model_flush();

    // ---------------- monitor ----------------
    logic [NUM_CH-1:0] prev_div = '0;
    int                m_rise [NUM_CH];
    int                m_w    [NUM_CH];
    int                m_ep   [NUM_CH];
    bit                m_ok   [NUM_CH];

    always @(negedge clk) begin
        check("locked", 32'(locked), 32'(lock_edges >= LOCK));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            item_t it;
            if (exp_q[ch].size() > 0 && exp_q[ch][0].rise == cyc) begin
                it = exp_q[ch].pop_front();
                check($sformatf("clk_en_pulse_ch%0d", ch), 32'(clk_en[ch]), 32'd1);
                check($sformatf("clk_div_rise_ch%0d", ch), 32'({prev_div[ch], clk_div[ch]}), 32'd1);
                m_rise[ch] = cyc;
                m_w[ch]    = it.width;
                m_ep[ch]   = it.epoch;
                m_ok[ch]   = 1'b1;
            end else begin
                check($sformatf("clk_en_quiet_ch%0d", ch), 32'(clk_en[ch]), 32'd0);
                check($sformatf("clk_div_no_rise_ch%0d", ch), 32'(!prev_div[ch] && clk_div[ch]), 32'd0);
            end
            if (prev_div[ch] && !clk_div[ch] && m_ok[ch]) begin
                m_ok[ch] = 1'b0;
                if (m_ep[ch] == epoch[ch])
                    check($sformatf("high_width_ch%0d", ch), cyc - m_rise[ch], m_w[ch]);
            end
            prev_div[ch] = clk_div[ch];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_rise(input int ch, output int at);
        logic pv;
        pv = clk_div[ch];
        at = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pv && clk_div[ch]) begin
                at = cyc;
                break;
            end
            pv = clk_div[ch];
        end
        if (at < 0) timeout_fail($sformatf("rise_timeout_ch%0d", ch));
    endtask

    task automatic measure_period(input int ch, output int p);
        int r0, r1;
        wait_rise(ch, r0);
        wait_rise(ch, r1);
        p = (r0 < 0 || r1 < 0) ? -1 : r1 - r0;
    endtask

    task automatic wait_lock(input int c0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (locked === 1'b1) begin
                check("lock_cycle", cyc - c0, LOCK);
                return;
            end
        end
        timeout_fail("lock_timeout");
    endtask

`ifdef CLKDIV_ALIGN_EN
    task automatic run_align_test();
        int r0, c0, ra0, ra1;
        logic [NUM_CH-1:0] pv;
        set_div(0, 4);
        set_div(1, 4);
        ch_en = 2'b01;
        repeat (20) @(negedge clk);
        wait_rise(0, r0);
        repeat (2) @(negedge clk);
        ch_en = 2'b11;
        repeat (13) @(negedge clk);
        align_req = 1'b1;
        c0        = cyc;
        @(negedge clk);
        align_req = 1'b0;
        ra0 = -1;
        ra1 = -1;
        pv  = clk_div;
        for (int i = 0; i < 40 && (ra0 < 0 || ra1 < 0); i++) begin
            @(negedge clk);
            if (ra0 < 0 && !pv[0] && clk_div[0]) ra0 = cyc;
            if (ra1 < 0 && !pv[1] && clk_div[1]) ra1 = cyc;
            pv = clk_div;
        end
        if (ra0 < 0 || ra1 < 0) begin
            timeout_fail("align_rise_timeout");
        end else begin
            check("align_first_rise_ch0", ra0 - (c0 + 1), 4);
            check("align_first_rise_ch1", ra1 - (c0 + 1), 4);
        end
    endtask
`else
    task automatic run_align_test();
        int r0, r1;
        set_div(0, 4);
        set_div(1, 4);
        ch_en = 2'b11;
        repeat (20) @(negedge clk);
        wait_rise(0, r0);
        repeat (2) @(negedge clk);
        align_req = 1'b1;
        @(negedge clk);
        align_req = 1'b0;
        wait_rise(0, r1);
        check("align_ignored_period", r1 - r0, 8);
    endtask
`endif

    // ---------------- directed + random stimulus ----------------
    initial begin
        int c0, r0, r1, p, cnt, k;

        set_div(0, 3);
        set_div(1, 5);
        ch_en = 2'b11;
        repeat (3) @(negedge clk);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_clk_div", 32'(clk_div), 32'd0);
        check("reset_clk_en", 32'(clk_en), 32'd0);

        rst_n = 1'b1;
        c0    = cyc;
        wait_lock(c0);
        measure_period(0, p);
        check("period_ch0_div3", p, 6);
        measure_period(1, p);
        check("period_ch1_div5", p, 10);

        // Divide change in the middle of a high phase.
        wait_rise(0, r0);
        set_div(0, 7);
        wait_rise(0, r1);
        check("div_change_current_period", r1 - r0, 10);
        measure_period(0, p);
        check("period_ch0_div7", p, 14);

        // Disable ch1 mid-period, then re-enable.
        wait_rise(1, r0);
        repeat (2) @(negedge clk);
        ch_en[1] = 1'b0;
        r1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!clk_div[1]) begin
                r1 = cyc;
                break;
            end
        end
        if (r1 < 0) timeout_fail("ch1_fall_timeout");
        else        check("ch1_finishes_high_phase", r1 - r0, 5);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (clk_div[1] || clk_en[1]) cnt++;
        end
        check("ch1_idle_after_disable", cnt, 0);
        ch_en[1] = 1'b1;
        c0       = cyc;
        wait_rise(1, r1);
        check("ch1_restart_first_rise", r1 - (c0 + 1), 5);

        // Zero divide with the channel enabled.
        set_div(0, 0);
        repeat (20) @(negedge clk);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (clk_div[0] || clk_en[0]) cnt++;
        end
        check("div0_channel_idle", cnt, 0);

        run_align_test();

        // Reset in the middle of a high phase.
        wait_rise(0, r0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clk_div", 32'(clk_div), 32'd0);
        check("async_reset_clk_en", 32'(clk_en), 32'd0);
        check("async_reset_locked", 32'(locked), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0    = cyc;
        wait_lock(c0);
        measure_period(0, p);
        check("period_ch0_after_reset", p, 8);

        // Random traffic; the scoreboard checks every edge.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            align_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0)
                set_div(int'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 19) == 0) begin
                k        = int'($urandom_range(0, 1));
                ch_en[k] = ~ch_en[k];
            end
        end
        align_req = 1'b0;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
